// File: rtl/keypad_entry_ctrl.sv
// 4x4 keypad scanner, debouncer and NUM_DIGITS-digit BCD entry sequencer.
// Define HOLD_REPEAT_EN to re-pulse key_valid while a key stays held.
module keypad_entry_ctrl #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int NUM_DIGITS     = 3,
  parameter int REPEAT_SCANS   = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  output logic [3:0]                        col_out,
  input  logic [3:0]                        row_in,
  output logic [15:0]                       key_onehot,
  output logic                              key_valid,
  output logic [4*NUM_DIGITS-1:0]           digits,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   digit_count,
  output logic                              entry_done,
  output logic                              overflow
);

  localparam int DW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DBW = $clog2(DEBOUNCE_SCANS + 1);
  localparam int CW  = $clog2(NUM_DIGITS + 1);
  localparam logic [DBW-1:0] DB_MAX = DBW'(DEBOUNCE_SCANS);
  localparam logic [CW-1:0]  FULL   = CW'(NUM_DIGITS);

  if (DEBOUNCE_SCANS < 1 || REPEAT_SCANS < 1) begin : g_bad_param
    $error("keypad_entry_ctrl: DEBOUNCE_SCANS and REPEAT_SCANS must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;

  state_t          state;
  logic [DW-1:0]   div;
  logic [1:0]      col;
  logic [15:0]     raw;
  logic [15:0]     cand;
  logic [DBW-1:0]  cnt;
  logic            frame;
  logic            done_flag;
  logic            dig_hit;
  logic [3:0]      dig;

  wire last = (div == DW'(SCAN_DIV - 1));

  // raw is complete after column 3 is sampled; frame flags it next cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div     <= '0;
      col     <= 2'd0;
      col_out <= 4'b1110;
      raw     <= '0;
      frame   <= 1'b0;
    end else begin
      frame <= 1'b0;
      if (last) begin
        div                 <= '0;
        col                 <= col + 2'd1;
        col_out             <= ~(4'b0001 << (col + 2'd1));
        raw[{col, 2'b00}+:4] <= ~row_in;
        frame               <= (col == 2'd3);
      end else begin
        div <= div + DW'(1);
      end
    end
  end

`ifdef HOLD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_SCANS + 1);
  localparam int STEP = (REPEAT_SCANS / 4 > 0) ? REPEAT_SCANS / 4 : 1;
  logic [RW-1:0] rep_cnt;
  logic          rep_arm;
  wire [RW-1:0]  rep_tgt = rep_arm ? RW'(STEP) : RW'(REPEAT_SCANS);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cand       <= '0;
      cnt        <= '0;
      key_onehot <= '0;
      key_valid  <= 1'b0;
`ifdef HOLD_REPEAT_EN
      rep_cnt    <= '0;
      rep_arm    <= 1'b0;
`endif
    end else begin
      key_valid <= 1'b0;
`ifdef HOLD_REPEAT_EN
      if (state != HELD) begin
        rep_cnt <= '0;
        rep_arm <= 1'b0;
      end
`endif
      if (frame) begin
        unique case (state)
          IDLE: begin
            if ($onehot(raw)) begin
              cand <= raw;
              cnt  <= DBW'(1);
              if (DB_MAX == DBW'(1)) begin
                state      <= HELD;
                key_onehot <= raw;
                key_valid  <= 1'b1;
              end else begin
                state <= PRESS_DB;
              end
            end
          end
          PRESS_DB: begin
            if (raw == cand) begin
              cnt <= cnt + DBW'(1);
              if (cnt + DBW'(1) == DB_MAX) begin
                state      <= HELD;
                key_onehot <= cand;
                key_valid  <= 1'b1;
              end
            end else begin
              state <= IDLE;
              cnt   <= '0;
            end
          end
          HELD: begin
            if (raw == '0) begin
              cnt <= DBW'(1);
              if (DB_MAX == DBW'(1)) begin
                state      <= IDLE;
                key_onehot <= '0;
              end else begin
                state <= REL_DB;
              end
            end else begin
`ifdef HOLD_REPEAT_EN
              if (rep_cnt + RW'(1) == rep_tgt) begin
                key_valid <= 1'b1;
                rep_cnt   <= '0;
                rep_arm   <= 1'b1;
              end else begin
                rep_cnt <= rep_cnt + RW'(1);
              end
`endif
            end
          end
          REL_DB: begin
            if (raw == '0) begin
              cnt <= cnt + DBW'(1);
              if (cnt + DBW'(1) == DB_MAX) begin
                state      <= IDLE;
                cnt        <= '0;
                key_onehot <= '0;
              end
            end else begin
              state <= HELD;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    dig_hit = 1'b1;
    dig     = 4'd0;
    unique case (1'b1)
      key_onehot[3]:  dig = 4'd0;
      key_onehot[7]:  dig = 4'd1;
      key_onehot[6]:  dig = 4'd2;
      key_onehot[5]:  dig = 4'd3;
      key_onehot[11]: dig = 4'd4;
      key_onehot[10]: dig = 4'd5;
      key_onehot[9]:  dig = 4'd6;
      key_onehot[15]: dig = 4'd7;
      key_onehot[14]: dig = 4'd8;
      key_onehot[13]: dig = 4'd9;
      default:        dig_hit = 1'b0;
    endcase
  end

  // done_flag makes the first digit after ENTER start a fresh entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits      <= '1;
      digit_count <= '0;
      entry_done  <= 1'b0;
      overflow    <= 1'b0;
      done_flag   <= 1'b0;
    end else begin
      entry_done <= 1'b0;
      overflow   <= 1'b0;
      if (key_valid) begin
        unique case (1'b1)
          dig_hit: begin
            if (done_flag) begin
              digits      <= {{(NUM_DIGITS-1){4'hF}}, dig};
              digit_count <= CW'(1);
              done_flag   <= 1'b0;
            end else if (digit_count == FULL) begin
              overflow <= 1'b1;
            end else begin
              digits      <= {digits[4*NUM_DIGITS-5:0], dig};
              digit_count <= digit_count + CW'(1);
            end
          end
          key_onehot[0]: begin
            digits      <= '1;
            digit_count <= '0;
            done_flag   <= 1'b0;
          end
          key_onehot[1]: begin
            if (digit_count != '0) begin
              digits      <= {4'hF, digits[4*NUM_DIGITS-1:4]};
              digit_count <= digit_count - CW'(1);
            end
          end
          key_onehot[2]: begin
            entry_done <= 1'b1;
            done_flag  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Bench for keypad_entry_ctrl: keypad pin model, directed edits and random
// key presses checked against a queue-based entry model.
module tb_keypad_entry_ctrl;

  localparam int ND = 3;
  localparam int FR = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  col_out;
  logic [3:0]  row_in;
  logic [15:0] key_onehot;
  logic        key_valid;
  logic [11:0] digits;
  logic [1:0]  digit_count;
  logic        entry_done;
  logic        overflow;

  logic [15:0] pressed = '0;
  int vectors = 0;
  int miscompares = 0;
  int kv_cnt = 0, done_cnt = 0, ovf_cnt = 0;
  int kv0, done0, ovf0;
  int q[$];
  bit mdone = 0;
  int exp_done, exp_ovf;

  keypad_entry_ctrl #(
    .SCAN_DIV(2), .DEBOUNCE_SCANS(2),
    .NUM_DIGITS(ND), .REPEAT_SCANS(4)
  ) dut (
    .clk(clk), .rst(rst), .col_out(col_out), .row_in(row_in),
    .key_onehot(key_onehot), .key_valid(key_valid),
    .digits(digits), .digit_count(digit_count),
    .entry_done(entry_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // pressed switch at (c,r) shorts column c to row r
  always_comb begin
    row_in = 4'hF;
    for (int c = 0; c < 4; c++)
      if (!col_out[c])
        for (int r = 0; r < 4; r++)
          if (pressed[c*4+r]) row_in[r] = 1'b0;
  end

  always @(posedge clk) begin
    if (key_valid)  kv_cnt++;
    if (entry_done) done_cnt++;
    if (overflow)   ovf_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int digit_of(input logic [15:0] k);
    case (k)
      16'h0008: return 0;
      16'h0080: return 1;
      16'h0040: return 2;
      16'h0020: return 3;
      16'h0800: return 4;
      16'h0400: return 5;
      16'h0200: return 6;
      16'h8000: return 7;
      16'h4000: return 8;
      16'h2000: return 9;
      default:  return -1;
    endcase
  endfunction

  function automatic logic [11:0] mdigits();
    logic [11:0] v = '1;
    for (int i = 0; i < q.size(); i++)
      v[4*(q.size()-1-i) +: 4] = 4'(q[i]);
    return v;
  endfunction

  task automatic model(input logic [15:0] k);
    int d = digit_of(k);
    exp_done = 0;
    exp_ovf  = 0;
    if (d >= 0) begin
      if (mdone) begin
        q.delete();
        mdone = 0;
      end
      if (q.size() < ND) q.push_back(d);
      else exp_ovf = 1;
    end else if (k == 16'h0001) begin
      q.delete();
      mdone = 0;
    end else if (k == 16'h0002) begin
      if (q.size() > 0) void'(q.pop_back());
    end else if (k == 16'h0004) begin
      exp_done = 1;
      mdone = 1;
    end
  endtask

  task automatic snap();
    kv0 = kv_cnt;
    done0 = done_cnt;
    ovf0 = ovf_cnt;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic key_step(input string tag, input logic [15:0] k,
                          input int frames);
    snap();
    pressed = k;
    cycles(frames * FR);
    check({tag, ".held"}, key_onehot, k);
    pressed = '0;
    cycles(5 * FR);
    check({tag, ".rel"}, key_onehot, 0);
    check({tag, ".kv"}, kv_cnt - kv0, 1);
    model(k);
    check({tag, ".done"}, done_cnt - done0, exp_done);
    check({tag, ".ovf"}, ovf_cnt - ovf0, exp_ovf);
    check({tag, ".digits"}, digits, mdigits());
    check({tag, ".count"}, digit_count, q.size());
  endtask

  initial begin
    rst = 1'b1;
    cycles(3);
    check("rst.col", col_out, 4'b1110);
    check("rst.digits", digits, 12'hFFF);
    check("rst.count", digit_count, 0);
    check("rst.pulses", {key_valid, entry_done, overflow}, 0);
    check("rst.key", key_onehot, 0);
    rst = 1'b0;
    cycles(2);

    key_step("d1", 16'h0080, 5);
    key_step("d2", 16'h0040, 5);
    key_step("d3", 16'h0020, 5);
    check("d123", digits, 12'h123);
    key_step("d4ovf", 16'h0800, 5);
    key_step("bs1", 16'h0002, 5);
    check("bs.F12", digits, 12'hF12);
    key_step("clr", 16'h0001, 5);
    key_step("bs0", 16'h0002, 5);
    check("bs0.FFF", digits, 12'hFFF);
    key_step("d4", 16'h0800, 5);
    key_step("d5", 16'h0400, 5);
    key_step("ent", 16'h0004, 5);
    check("ent.F45", digits, 12'hF45);
    key_step("d7", 16'h8000, 5);
    check("d7.FF7", digits, 12'hFF7);

    snap();
    pressed = 16'h0080;
    cycles(FR);
    pressed = '0;
    cycles(5 * FR);
    check("glitch.kv", kv_cnt - kv0, 0);

    snap();
    pressed = 16'h00C0;
    cycles(5 * FR);
    check("multi.key", key_onehot, 0);
    pressed = '0;
    cycles(5 * FR);
    check("multi.kv", kv_cnt - kv0, 0);

    key_step("hold8", 16'h4000, 12);
    key_step("ign", 16'h0100, 5);

    pressed = 16'h0800;
    cycles(5 * FR);
    check("midrst.held", key_onehot, 16'h0800);
    rst = 1'b1;
    #1;
    check("midrst.key", key_onehot, 0);
    check("midrst.col", col_out, 4'b1110);
    check("midrst.digits", digits, 12'hFFF);
    check("midrst.count", digit_count, 0);
    q.delete();
    mdone = 0;
    pressed = '0;
    cycles(3);
    rst = 1'b0;
    cycles(2);

    for (int i = 0; i < 24; i++) begin
      logic [15:0] k;
      k = 16'h0001 << $urandom_range(15, 0);
      key_step($sformatf("rnd%0d", i), k, 5);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/keypad_entry_ctrl.md
Name: keypad_entry_ctrl

Overview:
Scan and entry controller for the 4x4 matrix keypad.
- Drives the columns, samples the rows and builds a 16-bit raw key vector once per frame.
- Debounces the vector and emits a one-hot key strobe that the keypad encoder consumes.
- Sequences a NUM_DIGITS-digit BCD entry with clear, backspace and enter keys.
- Sits between the keypad pins and the seven-segment display path.

Parameters:
- SCAN_DIV, 50000: clk cycles each column is driven before its rows are sampled.
- DEBOUNCE_SCANS, 4: consecutive identical frames needed to accept a press or a release (minimum 1).
- NUM_DIGITS, 3: number of BCD digits held in the entry register.
- REPEAT_SCANS, 64: frames a key must stay held before it repeats (used only with HOLD_REPEAT_EN).

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous, active-high reset.
- col_out, output, 4: column drive, active-low; exactly one bit is low at any time.
- row_in, input, 4: row sense, active-low, externally pulled up.
- key_onehot, output, 16: debounced key, one-hot; bit index = col*4 + row; all zeros when no key is held.
- key_valid, output, 1: one-cycle pulse on each accepted press.
- digits, output, 4*NUM_DIGITS: entry register; digits[3:0] holds the newest digit; a nibble of 4'hF means blank.
- digit_count, output, clog2(NUM_DIGITS+1): number of valid digits.
- entry_done, output, 1: one-cycle pulse when enter is pressed.
- overflow, output, 1: one-cycle pulse when a digit is pressed while the register is full.

Behaviour:
- Reset values: col_out=4'b1110, key_onehot=0, key_valid=0, digits=all 1s, digit_count=0, entry_done=0, overflow=0. All internal counters clear; the scan FSM goes to IDLE.
- Scan timing:
  - Column index c counts 0..3, advancing every SCAN_DIV cycles; col_out = ~(1<<c).
  - On the last cycle of each dwell, raw[c*4+r] = ~row_in[r].
  - When c wraps from 3 to 0, the frame is complete and is evaluated on the next cycle. Frame period = 4*SCAN_DIV.
- Scan FSM, evaluated once per frame:
  - IDLE: raw one-hot -> PRESS_DB with cand=raw, cnt=1.
  - PRESS_DB:
    - raw==cand -> cnt++.
    - raw differs -> back to IDLE with cnt=0.
    - cnt reaches DEBOUNCE_SCANS -> HELD. In the same cycle key_onehot=cand and key_valid pulses.
  - HELD: raw==0 -> REL_DB with cnt=1. Any nonzero raw keeps the FSM in HELD.
  - REL_DB:
    - raw==0 -> cnt++; at DEBOUNCE_SCANS go to IDLE and set key_onehot=0.
    - raw!=0 -> back to HELD.
  - Raw vectors with zero or more than one bit set never start a press (multi-key presses are rejected).
  - With DEBOUNCE_SCANS=1 a press is accepted on its first one-hot frame.
- Key map:
  - Digit bits: 0x0008=0, 0x0080=1, 0x0040=2, 0x0020=3, 0x0800=4, 0x0400=5, 0x0200=6, 0x8000=7, 0x4000=8, 0x2000=9.
  - Function bits: 0x0001=CLEAR, 0x0002=BACKSPACE, 0x0004=ENTER.
  - Bits 0x0010, 0x0100 and 0x1000 are ignored by the entry logic.
- Entry logic acts on the key_valid cycle; its outputs register one cycle later.
  - Digit d with count<NUM_DIGITS: digits={digits[4*NUM_DIGITS-5:0],d}; count++.
  - Digit d with count==NUM_DIGITS: no change; overflow pulses.
  - CLEAR: digits=all 1s; count=0.
  - BACKSPACE with count>0: digits={4'hF,digits[4*NUM_DIGITS-1:4]}; count--. With count==0: no-op.
  - ENTER: entry_done pulses; digits and count are held.
  - First digit after an ENTER: the register clears first, then the digit is loaded as a fresh entry with count=1. A sticky done flag tracks this and clears on the next digit or CLEAR.
- Reset mid-scan or mid-entry returns everything to the reset values immediately.
- Key pulses are separated by at least one frame, so entry actions never coincide.

Optional Feature:
- Macro: HOLD_REPEAT_EN.
- Defined: in HELD, a frame counter starts on acceptance. After REPEAT_SCANS frames, and every REPEAT_SCANS/4 frames after that (minimum 1), key_valid re-pulses with the same key_onehot; the entry logic treats each pulse as a new press. The counter resets on leaving HELD.
- Undefined: exactly one key_valid pulse per press; the repeat counter is not built.

Test Plan:
- All tests use SCAN_DIV=2 and DEBOUNCE_SCANS=2 unless noted.
- Reset:
  - Assert rst for 3 cycles -> col_out=1110, digits=12'hFFF, digit_count=0, no pulses.
  - Assert rst mid-HELD -> key_onehot=0 immediately.
- Digit entry: press key 0x0080 ("1"), then 0x0040 ("2"), then 0x0020 ("3"), each held 4 frames -> exactly 3 key_valid pulses; digits=12'h123, digit_count=3. A fourth digit "4" -> overflow pulse; digits stay 12'h123.
- Debounce: row low for 1 frame only, then high -> no key_valid. A two-key frame (raw=0x00C0) held 5 frames -> no key_valid.
- Edit keys: starting from 12'h123, BACKSPACE -> 12'hF12, count=2. Then CLEAR -> 12'hFFF, count=0. Then BACKSPACE -> still 12'hFFF, count=0.
- Enter and restart: enter "4","5", then ENTER -> entry_done pulses once with digits=12'hF45. Then press "7" -> digits=12'hFF7, count=1.
- Repeat (HOLD_REPEAT_EN defined, REPEAT_SCANS=4): hold "8" for 12 frames -> key_valid at acceptance, then at +4, +5, +6 … frames. Without the macro -> a single pulse.
